seq_dense_layer: RTL

SEQ_DENSE_LAYER -- requirements
Module: seq_dense_layer

---
 rtl/seq_dense_layer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/seq_dense_layer.sv
// Sequential dense layer: LANES MAC units are time-shared over OUT_SIZE neurons (LOAD -> COMPUTE -> DRAIN).
// Optional feature macro SEQ_DENSE_ARGMAX_EN adds out_argmax (index of the largest result, lowest on tie).
module seq_dense_layer #(
  parameter int IN_SIZE  = 64,
  parameter int OUT_SIZE = 8,
  parameter int LANES    = 2,
  parameter int WIDTH    = 18,
  parameter int FRAC     = 8,
  parameter int ACT      = 1,
  localparam int WA = (OUT_SIZE * IN_SIZE > 1) ? $clog2(OUT_SIZE * IN_SIZE) : 1,
  localparam int NW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_wr_en,
  input  logic [WA-1:0]    w_wr_addr,
  input  logic [WIDTH-1:0] w_wr_data,
  input  logic             b_wr_en,
  input  logic [NW-1:0]    b_wr_addr,
  input  logic [WIDTH-1:0] b_wr_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
`ifdef SEQ_DENSE_ARGMAX_EN
  output logic [NW-1:0]    out_argmax,
`endif
  output logic             busy
);

  localparam int G  = OUT_SIZE / LANES;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int KW = $clog2(IN_SIZE + 1);
  localparam int XW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int PW = 2 * WIDTH;
  localparam int AW = 2 * WIDTH + $clog2(IN_SIZE) + 1;
  localparam logic signed [AW:0] SAT_MAX = {{(AW + 2 - WIDTH){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [AW:0] SAT_MIN = {{(AW + 2 - WIDTH){1'b1}}, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {S_LOAD = 2'd0, S_COMPUTE = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t r_state, w_next;
  logic             r_loaded;
  logic [KW-1:0]    r_k;
  logic [GW-1:0]    r_g;
  logic [NW-1:0]    r_n;
  logic [WIDTH-1:0] r_w   [OUT_SIZE*IN_SIZE];
  logic [WIDTH-1:0] r_b   [OUT_SIZE];
  logic [WIDTH-1:0] r_x   [IN_SIZE];
  logic [WIDTH-1:0] r_res [OUT_SIZE];
  logic signed [AW-1:0] r_acc [LANES];

  logic [XW-1:0]        w_kx;
  logic [WIDTH-1:0]     w_wsel [LANES];
  logic [WIDTH-1:0]     w_bsel [LANES];
  logic signed [PW-1:0] w_prod [LANES];
  logic signed [AW:0]   w_sum  [LANES];
  logic signed [AW:0]   w_val  [LANES];
  logic [WIDTH-1:0]     w_fin  [LANES];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_next;
  end

  // Next-state logic; r_loaded gives the one-cycle gap after the last input beat
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:    w_next = r_loaded ? S_COMPUTE : S_LOAD;
      S_COMPUTE: w_next = (r_g == GW'(G - 1) && r_k == KW'(IN_SIZE)) ? S_DRAIN : S_COMPUTE;
      S_DRAIN:   w_next = (out_ready && r_n == NW'(OUT_SIZE - 1)) ? S_LOAD : S_DRAIN;
      default:   w_next = S_LOAD;
    endcase
  end

  // MAC products and finalize path (bias add, floor shift, activation, saturation)
  always_comb begin
    w_kx = (r_k < KW'(IN_SIZE)) ? XW'(r_k) : '0;
    for (int l = 0; l < LANES; l++) begin
      w_wsel[l] = r_w[WA'((int'(r_g) * LANES + l) * IN_SIZE + int'(w_kx))];
      w_bsel[l] = r_b[NW'(int'(r_g) * LANES + l)];
      w_prod[l] = $signed({{WIDTH{r_x[w_kx][WIDTH-1]}}, r_x[w_kx]})
                * $signed({{WIDTH{w_wsel[l][WIDTH-1]}}, w_wsel[l]});
      w_sum[l]  = $signed({r_acc[l][AW-1], r_acc[l]})
                + ($signed({{(AW + 1 - WIDTH){w_bsel[l][WIDTH-1]}}, w_bsel[l]}) <<< FRAC);
      w_val[l]  = ((ACT == 1) && w_sum[l][AW]) ? '0 : (w_sum[l] >>> FRAC);
      if (w_val[l] > SAT_MAX)      w_fin[l] = SAT_MAX[WIDTH-1:0];
      else if (w_val[l] < SAT_MIN) w_fin[l] = SAT_MIN[WIDTH-1:0];
      else                         w_fin[l] = w_val[l][WIDTH-1:0];
    end
  end

  // Counters and accumulators
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_loaded <= 1'b0;
      r_k      <= '0;
      r_g      <= '0;
      r_n      <= '0;
      for (int l = 0; l < LANES; l++) r_acc[l] <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (r_loaded) begin
            r_loaded <= 1'b0;
          end else if (in_valid) begin
            if (r_k == KW'(IN_SIZE - 1)) begin
              r_k      <= '0;
              r_loaded <= 1'b1;
            end else begin
              r_k <= r_k + KW'(1);
            end
          end
        end
        S_COMPUTE: begin
          if (r_k == KW'(IN_SIZE)) begin
            r_k <= '0;
            r_g <= (r_g == GW'(G - 1)) ? '0 : r_g + GW'(1);
            for (int l = 0; l < LANES; l++) r_acc[l] <= '0;
          end else begin
            r_k <= r_k + KW'(1);
            for (int l = 0; l < LANES; l++)
              r_acc[l] <= r_acc[l] + $signed({{(AW - PW){w_prod[l][PW-1]}}, w_prod[l]});
          end
        end
        S_DRAIN: begin
          if (out_ready) r_n <= (r_n == NW'(OUT_SIZE - 1)) ? '0 : r_n + NW'(1);
        end
        default: r_k <= '0;
      endcase
    end
  end

  // Storage: parameters survive reset, only writable while loading
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && w_wr_en && int'(w_wr_addr) < OUT_SIZE * IN_SIZE) r_w[w_wr_addr] <= w_wr_data;
    if (r_state == S_LOAD && b_wr_en && int'(b_wr_addr) < OUT_SIZE) r_b[b_wr_addr] <= b_wr_data;
    if (r_state == S_LOAD && in_valid && !r_loaded) r_x[XW'(r_k)] <= in_data;
    if (r_state == S_COMPUTE && r_k == KW'(IN_SIZE))
      for (int l = 0; l < LANES; l++) r_res[NW'(int'(r_g) * LANES + l)] <= w_fin[l];
  end

  assign in_ready  = (r_state == S_LOAD) && !r_loaded;
  assign busy      = (r_state == S_COMPUTE) || (r_state == S_DRAIN);
  assign out_valid = (r_state == S_DRAIN);
  assign out_data  = out_valid ? r_res[r_n] : '0;
  assign out_last  = out_valid && (r_n == NW'(OUT_SIZE - 1));

`ifdef SEQ_DENSE_ARGMAX_EN
  logic [NW-1:0] w_amax;

  // Strict greater-than keeps the lowest index on ties
  always_comb begin
    w_amax = '0;
    for (int i = 1; i < OUT_SIZE; i++)
      w_amax = ($signed(r_res[i]) > $signed(r_res[w_amax])) ? NW'(i) : w_amax;
  end

  assign out_argmax = out_valid ? w_amax : '0;
`endif

endmodule
